fetch_prefetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decode stage. Owns the PC and issues reads to the instruction memory.

---
 rtl/fetch_prefetch_unit_pkg.sv | 19 +
 rtl/fetch_prefetch_unit_queue.sv | 55 +++++
 rtl/fetch_prefetch_unit.sv | 78 +++++++
 tb/tb_fetch_prefetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// fetch_prefetch_unit_pkg: fetch FSM states and instruction field positions shared with decode
package fetch_prefetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RS2_MSB = 11;
    localparam int RS2_LSB = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 0;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// fetch_prefetch_unit_queue: circular FIFO with clear and count; output holds the last head when empty
module fetch_prefetch_unit_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  last;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = count != '0;
    assign do_pop  = pop && valid;
    assign do_push = push && (count != (PW+1)'(DEPTH) || do_pop);
    assign dout    = valid ? mem[rd_ptr] : last;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (valid) last <= dout;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(do_push);
                rd_ptr <= rd_ptr + PW'(do_pop);
                count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            end
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC, fetch FSM and credit-checked instruction memory reads feeding a prefetch queue
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int MEM_W   = 32,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic                     imem_rd,
    input  logic [MEM_W-1:0]         imem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   req_pc;
    logic                inflight;
    logic                issue;
    logic                push;
    logic                pop;
    logic                unused_rdata;

    // the inflight response holds a credit so a push never meets a full queue
    always_comb begin
        state_n = redirect ? S_FLUSH : fetch_en ? S_FETCH : S_IDLE;
        issue   = state == S_FETCH && !redirect && (q_count + CW'(inflight) < CW'(DEPTH));
    end

    assign imem_rd      = issue;
    assign imem_addr    = pc;
    assign push         = inflight && !redirect;
    assign pop          = instr_valid && instr_ready && !redirect;
    assign unused_rdata = ^imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            state    <= state_n;
            inflight <= issue;
            if (issue) req_pc <= pc;
            pc <= redirect ? redirect_pc : issue ? pc + ADDR_W'(1) : pc;
        end
    end

    fetch_prefetch_unit_queue #(
        .DEPTH(DEPTH),
        .W    (ADDR_W + INSTR_W)
    ) u_queue (
        .clk  (clk),
        .rst  (rst),
        .clear(redirect),
        .push (push),
        .pop  (pop),
        .din  ({req_pc, imem_rdata[INSTR_W-1:0]}),
        .dout ({instr_pc, instr}),
        .valid(instr_valid),
        .count(q_count)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed scenarios plus randomized traffic checked against an in-order PC stream model
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic        instr_ready = 1'b0;
    logic [4:0]  redirect_pc = '0;
    logic [4:0]  imem_addr;
    logic [4:0]  instr_pc;
    logic        imem_rd;
    logic        instr_valid;
    logic [31:0] imem_rdata = '0;
    logic [15:0] instr;
    logic [2:0]  q_count;
    logic [31:0] mem [32];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd) imem_rdata <= mem[imem_addr];

    fetch_prefetch_unit dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .q_count(q_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%0b want=0", imem_rd); end
        total++; if (imem_addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", instr_valid); end
        total++; if (instr !== 16'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
        total++; if (instr_pc !== 5'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", instr_pc); end
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", q_count); end
        rst = 1'b0;
        cyc();
        cyc();
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL idle_rd got=%0b want=0", imem_rd); end
    endtask

    task automatic test_stream();
        apply_reset();
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        cyc();
        total++; if ({imem_rd, imem_addr} !== {1'b1, 5'd0}) begin bad++; $display("FAIL stream_first_rd got=%b/%0d want=1/0", imem_rd, imem_addr); end
        cyc();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid got=%0b want=0", instr_valid); end
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 5'(k), 16'h1000 + 16'(k)}) begin
                bad++;
                $display("FAIL stream_k%0d got=%b/%0d/%h want=1/%0d/%h", k, instr_valid, instr_pc, instr, k, 16'h1000 + 16'(k));
            end
        end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int got = 0;
        int first = -1;
        apply_reset();
        fetch_en = 1'b1;
        repeat (10) begin
            cyc();
            if (imem_rd) issued++;
        end
        total++; if (issued != 4) begin bad++; $display("FAIL bp_issued got=%0d want=4", issued); end
        total++; if (q_count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d want=4", q_count); end
        total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL bp_rd got=%0b want=0", imem_rd); end
        instr_ready = 1'b1;
        for (int c = 0; c < 30 && got < 8; c++) begin
            if (instr_valid) begin
                total++;
                if (instr_pc !== 5'(got)) begin bad++; $display("FAIL bp_order got=%0d want=%0d", instr_pc, got); end
                got++;
            end
            if (imem_rd && first < 0) first = int'(imem_addr);
            cyc();
        end
        total++; if (got != 8) begin bad++; $display("FAIL bp_drain got=%0d want=8", got); end
        total++; if (first != 4) begin bad++; $display("FAIL bp_resume_addr got=%0d want=4", first); end
    endtask

    task automatic test_redirect_full();
        int got = 0;
        apply_reset();
        fetch_en = 1'b1;
        repeat (5) cyc();
        total++; if (q_count !== 3'd3) begin bad++; $display("FAIL rf_pre_count got=%0d want=3", q_count); end
        redirect = 1'b1;
        redirect_pc = 5'd20;
        cyc();
        redirect = 1'b0;
        total++; if ({instr_valid, q_count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL rf_flush got=%b/%0d want=0/0", instr_valid, q_count); end
        cyc();
        total++; if ({imem_rd, imem_addr} !== {1'b1, 5'd20}) begin bad++; $display("FAIL rf_read got=%b/%0d want=1/20", imem_rd, imem_addr); end
        cyc();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rf_early_valid got=%0b want=0", instr_valid); end
        cyc();
        total++; if ({instr_valid, instr_pc, instr} !== {1'b1, 5'd20, mem[20][15:0]}) begin bad++; $display("FAIL rf_head got=%b/%0d/%h want=1/20/%h", instr_valid, instr_pc, instr, mem[20][15:0]); end
        instr_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (instr_valid) begin
                total++;
                if (instr_pc !== 5'(20 + got)) begin bad++; $display("FAIL rf_order got=%0d want=%0d", instr_pc, 20 + got); end
                got++;
            end
            cyc();
        end
        total++; if (got != 4) begin bad++; $display("FAIL rf_drain got=%0d want=4", got); end
    endtask

    task automatic test_wrap();
        int got = 0;
        apply_reset();
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 5'd30;
        cyc();
        redirect = 1'b0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (instr_valid) begin
                total++;
                if (instr_pc !== 5'(30 + got)) begin bad++; $display("FAIL wrap_pc got=%0d want=%0d", instr_pc, 5'(30 + got)); end
                got++;
            end
            cyc();
        end
        total++; if (got != 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", got); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        fetch_en = 1'b1;
        repeat (5) cyc();
        #2 rst = 1'b1;
        #1;
        total++; if ({instr_valid, q_count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL ar_clear got=%b/%0d want=0/0", instr_valid, q_count); end
        total++; if ({imem_rd, imem_addr} !== {1'b0, 5'd0}) begin bad++; $display("FAIL ar_addr got=%b/%0d want=0/0", imem_rd, imem_addr); end
        cyc();
        rst = 1'b0;
        cyc();
        total++; if ({imem_rd, imem_addr} !== {1'b1, 5'd0}) begin bad++; $display("FAIL ar_restart got=%b/%0d want=1/0", imem_rd, imem_addr); end
    endtask

    task automatic test_redirect_accept();
        apply_reset();
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        repeat (5) cyc();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ra_pre_valid got=%0b want=1", instr_valid); end
        redirect = 1'b1;
        redirect_pc = 5'd9;
        cyc();
        redirect = 1'b0;
        total++; if ({instr_valid, q_count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL ra_flush got=%b/%0d want=0/0", instr_valid, q_count); end
        cyc();
        cyc();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ra_early got=%0b want=0", instr_valid); end
        cyc();
        total++; if ({instr_valid, instr_pc, instr} !== {1'b1, 5'd9, mem[9][15:0]}) begin bad++; $display("FAIL ra_head got=%b/%0d/%h want=1/9/%h", instr_valid, instr_pc, instr, mem[9][15:0]); end
    endtask

    task automatic test_random();
        logic [4:0]  exp_pc = '0;
        logic [4:0]  last_pc = '0;
        logic [15:0] last_instr = '0;
        int          accepted = 0;
        for (int k = 0; k < 32; k++) mem[k] = $urandom();
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            total++;
            if (q_count > 3'd4) begin bad++; $display("FAIL rnd_count got=%0d want<=4", q_count); end
            if (!instr_valid) begin
                total++;
                if ({instr_pc, instr} !== {last_pc, last_instr}) begin bad++; $display("FAIL rnd_hold got=%0d/%h want=%0d/%h", instr_pc, instr, last_pc, last_instr); end
            end
            fetch_en = $urandom_range(0, 9) != 0;
            instr_ready = $urandom_range(0, 2) != 0;
            redirect = $urandom_range(0, 29) == 0;
            redirect_pc = 5'($urandom());
            if (redirect) exp_pc = redirect_pc;
            else if (instr_valid && instr_ready) begin
                total++;
                if ({instr_pc, instr} !== {exp_pc, mem[exp_pc][15:0]}) begin bad++; $display("FAIL rnd_accept got=%0d/%h want=%0d/%h", instr_pc, instr, exp_pc, mem[exp_pc][15:0]); end
                exp_pc = exp_pc + 5'd1;
                accepted++;
            end
            if (instr_valid) {last_pc, last_instr} = {instr_pc, instr};
            cyc();
        end
        redirect = 1'b0;
        total++; if (accepted < 300) begin bad++; $display("FAIL rnd_progress got=%0d want>=300", accepted); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = {16'($urandom()), 16'h1000 + 16'(k)};
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_async_reset();
        test_redirect_accept();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
